cpu_core: RTL and testbench
===========================

# cpu_core

Single-cycle 4-bit execution core that sits directly downstream of the program ROM. It drives the ROM address from its program counter, decodes the returned 8-bit instruction (4-bit opcode, 4-bit immediate), and updates registers A and B, the carry flag, the PC, and the output port. There is one instruction per enabled clock and no pipeline.

## Interface
Parameters: none. Widths are fixed by the shared package (data 4 bits, instruction 8 bits).
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `en`  in  1  execute enable; low freezes all state
- `rom_addr`  out  4  instruction address, equal to the PC (combinational from the PC register)
- `rom_data`  in  8  instruction; [7:4] opcode, [3:0] immediate Im
- `in_port`  in  4  external input, sampled by IN instructions
- `out_port`  out  4  registered output port
- `dbg_a`, `dbg_b`  out  4  current A and B register values
- `dbg_c`  out  1  current carry flag

## Operation
Instruction set, with `r` = new value at the edge:
- 0000 ADD A,Im: {C,A} r= A+Im
- 0101 ADD B,Im: {C,B} r= B+Im
- 0011 MOV A,Im: A r= Im
- 0111 MOV B,Im: B r= Im
- 0001 MOV A,B: A r= B
- 0100 MOV B,A: B r= A
- 0010 IN A: A r= in_port
- 0110 IN B: B r= in_port
- 1001 OUT B: out_port r= B
- 1011 OUT Im: out_port r= Im
- 1111 JMP Im: PC r= Im
- 1110 JNC Im: PC r= Im if C==0, else PC+1

Common rules:
- Every non-jump instruction, and a JNC not taken, sets PC r= PC+1, mod 16. PC 15 wraps to 0.
- ADD is modulo 16. C takes the carry-out of bit 3.
- Every instruction other than ADD clears C, including JMP, JNC and NOP. JNC tests C before this clear.
- Undefined opcodes (1000, 1010, 1100, 1101) act as NOP: PC+1, C cleared, all other state held.
- Registers not named by an instruction hold their value. out_port changes only on OUT.

## Timing
- Reset: when rst_n is low at an edge, PC=0, A=0, B=0, C=0, out_port=0. Reset has priority over en.
- Reset applied mid-program behaves the same way. The first instruction after release is the one at address 0.
- rom_addr = PC with zero combinational logic in between. The ROM is combinational, so rom_data is valid in the same cycle.
- Latency: an instruction presented in cycle n has its effects visible on the outputs after edge n+1.
- en low: every register holds, including PC. rom_addr stays stable.
- in_port is sampled only at the executing edge. No synchronizer; the caller guarantees in_port is synchronous.
- No X-propagation: every opcode decodes to defined behaviour.

## Structure
- Shared package `cpu_pkg` holds:
  - `DATA_W`=4 and `INSTR_W`=8
  - the `opcode_t` enum with the 12 mnemonics above
  - the `instr_t` packed struct {opcode, imm}
- The ROM consumes `INSTR_W` from the same package.
- Sub-module `cpu_alu`: combinational 4-bit adder. Inputs are operand and Im; outputs are sum and carry. Operand select happens in the core.
- The core holds:
  - the PC, A, B, C and out_port registers
  - a combinational decoder producing the register load enables, the ALU operand select and the next-PC select

## Test plan
1. Reset then run the standard program (MOV B,0; IN A; ADD A,1; MOV B,A; OUT B; JMP 5) with in_port=3. Required: out_port=4 after the 5th enabled edge, then PC stays at 5 with out_port held at 4.
2. MOV A,15 then ADD A,1. Required: A=0, C=1. Then JNC 9 is not taken (PC+1) and C becomes 0. A second JNC 9 is taken (PC=9).
3. ADD B,7 with B=9. Required: B=0, C=1. A following MOV A,B gives A=0 and C=0.
4. JMP 15 followed by an instruction at 15 that is a NOP (1000_0000). Required: PC wraps to 0 and C=0.
5. Hold en low for 3 cycles in the middle of the program, with in_port changing. Required: PC, A, B, C and out_port unchanged. Execution resumes at the same address.
6. Assert rst_n=0 for one edge while A=5, out_port=4 and en=0. Required: all registers 0 and rom_addr=0 after that edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths, opcode encoding and instruction layout for the 4-bit core and its ROM.
package cpu_pkg;

  localparam int unsigned DATA_W  = 4;
  localparam int unsigned INSTR_W = 8;
  localparam int unsigned PC_W    = 4;

  typedef enum logic [3:0] {
    OP_ADD_A    = 4'b0000,
    OP_MOV_AB   = 4'b0001,
    OP_IN_A     = 4'b0010,
    OP_MOV_A_IM = 4'b0011,
    OP_MOV_BA   = 4'b0100,
    OP_ADD_B    = 4'b0101,
    OP_IN_B     = 4'b0110,
    OP_MOV_B_IM = 4'b0111,
    OP_OUT_B    = 4'b1001,
    OP_OUT_IM   = 4'b1011,
    OP_JNC      = 4'b1110,
    OP_JMP      = 4'b1111
  } opcode_t;

  typedef struct packed {
    opcode_t           opcode;
    logic [DATA_W-1:0] imm;
  } instr_t;

  // Register write-back source; SRC_OTHER means "the other general register".
  typedef enum logic [1:0] {
    SRC_IMM   = 2'd0,
    SRC_OTHER = 2'd1,
    SRC_IN    = 2'd2,
    SRC_ALU   = 2'd3
  } reg_src_t;

  typedef enum logic [1:0] {
    PC_INC = 2'd0,
    PC_JMP = 2'd1,
    PC_JNC = 2'd2
  } pc_sel_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational 4-bit adder; the core chooses which register feeds op_a_i.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              carry_o
);

  assign {carry_o, sum_o} = {1'b0, op_a_i} + {1'b0, imm_i};

endmodule

// File: rtl/cpu_core.sv
// Single-cycle 4-bit execution core: fetch from combinational ROM, decode, execute
// one instruction per enabled clock.
module cpu_core
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [PC_W-1:0]    rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic [DATA_W-1:0]  in_port,
  output logic [DATA_W-1:0]  out_port,
  output logic [DATA_W-1:0]  dbg_a,
  output logic [DATA_W-1:0]  dbg_b,
  output logic               dbg_c
);

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              c_q, c_d;

  instr_t            instr;
  logic              a_load, b_load, out_load, out_imm, alu_sel_b, c_from_alu;
  reg_src_t          a_src, b_src;
  pc_sel_t           pc_sel;
  logic [DATA_W-1:0] alu_op, alu_sum;
  logic              alu_carry;
  logic [PC_W-1:0]   pc_inc;

  assign instr = instr_t'(rom_data);

  // Decoder: load enables, operand select and next-PC select.
  always_comb begin
    a_load     = 1'b0;
    b_load     = 1'b0;
    a_src      = SRC_IMM;
    b_src      = SRC_IMM;
    out_load   = 1'b0;
    out_imm    = 1'b0;
    alu_sel_b  = 1'b0;
    c_from_alu = 1'b0;
    pc_sel     = PC_INC;
    case (instr.opcode)
      OP_ADD_A:    begin a_load = 1'b1; a_src = SRC_ALU; c_from_alu = 1'b1; end
      OP_ADD_B:    begin b_load = 1'b1; b_src = SRC_ALU; c_from_alu = 1'b1; alu_sel_b = 1'b1; end
      OP_MOV_A_IM: begin a_load = 1'b1; a_src = SRC_IMM; end
      OP_MOV_B_IM: begin b_load = 1'b1; b_src = SRC_IMM; end
      OP_MOV_AB:   begin a_load = 1'b1; a_src = SRC_OTHER; end
      OP_MOV_BA:   begin b_load = 1'b1; b_src = SRC_OTHER; end
      OP_IN_A:     begin a_load = 1'b1; a_src = SRC_IN; end
      OP_IN_B:     begin b_load = 1'b1; b_src = SRC_IN; end
      OP_OUT_B:    out_load = 1'b1;
      OP_OUT_IM:   begin out_load = 1'b1; out_imm = 1'b1; end
      OP_JMP:      pc_sel = PC_JMP;
      OP_JNC:      pc_sel = PC_JNC;
      default:     pc_sel = PC_INC;
    endcase
  end

  assign alu_op = alu_sel_b ? b_q : a_q;

  cpu_alu u_alu (
    .op_a_i  (alu_op),
    .imm_i   (instr.imm),
    .sum_o   (alu_sum),
    .carry_o (alu_carry)
  );

  assign pc_inc = pc_q + PC_W'(1);

  // Next-state datapath; every non-ADD instruction clears carry.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    out_d = out_q;
    c_d   = c_from_alu ? alu_carry : 1'b0;
    pc_d  = pc_inc;
    if (a_load) begin
      case (a_src)
        SRC_IMM:   a_d = instr.imm;
        SRC_OTHER: a_d = b_q;
        SRC_IN:    a_d = in_port;
        default:   a_d = alu_sum;
      endcase
    end
    if (b_load) begin
      case (b_src)
        SRC_IMM:   b_d = instr.imm;
        SRC_OTHER: b_d = a_q;
        SRC_IN:    b_d = in_port;
        default:   b_d = alu_sum;
      endcase
    end
    if (out_load) begin
      out_d = out_imm ? instr.imm : b_q;
    end
    case (pc_sel)
      PC_JMP:  pc_d = PC_W'(instr.imm);
      PC_JNC:  pc_d = c_q ? pc_inc : PC_W'(instr.imm);
      default: pc_d = pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= 1'b0;
      out_q <= '0;
    end else if (en) begin
      pc_q  <= pc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      out_q <= out_d;
    end
  end

  assign rom_addr = pc_q;
  assign out_port = out_q;
  assign dbg_a    = a_q;
  assign dbg_b    = b_q;
  assign dbg_c    = c_q;

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: directed programs plus random programs against
// an instruction-level reference model.
module tb_cpu_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic [3:0] in_port;
  logic [3:0] out_port;
  logic [3:0] dbg_a, dbg_b;
  logic       dbg_c;

  logic [7:0] rom [16];

  int checks = 0;
  int fails  = 0;
  bit chk_on = 1'b0;

  // Reference architectural state
  int m_pc, m_a, m_b, m_c, m_out;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  cpu_core dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .in_port  (in_port),
    .out_port (out_port),
    .dbg_a    (dbg_a),
    .dbg_b    (dbg_b),
    .dbg_c    (dbg_c)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Executes one instruction against the model, straight from the ISA rules.
  task automatic model_step(input bit r, input bit e, input int inp);
    int op, im, s, npc, nc;
    if (!r) begin
      m_pc = 0; m_a = 0; m_b = 0; m_c = 0; m_out = 0;
    end else if (e) begin
      op  = int'(rom[m_pc][7:4]);
      im  = int'(rom[m_pc][3:0]);
      npc = (m_pc + 1) % 16;
      nc  = 0;
      case (op)
        0:  begin s = m_a + im; nc = s / 16; m_a = s % 16; end
        5:  begin s = m_b + im; nc = s / 16; m_b = s % 16; end
        3:  m_a = im;
        7:  m_b = im;
        1:  m_a = m_b;
        4:  m_b = m_a;
        2:  m_a = inp;
        6:  m_b = inp;
        9:  m_out = m_b;
        11: m_out = im;
        15: npc = im;
        14: if (m_c == 0) npc = im;
        default: ;
      endcase
      m_c  = nc;
      m_pc = npc;
    end
  endtask

  // One clock: inputs are set after the falling edge, the model follows the rising edge.
  task automatic cyc(input bit r, input bit e, input int inp);
    rst_n   = r;
    en      = e;
    in_port = 4'(inp);
    @(posedge clk);
    model_step(r, e, inp);
    @(negedge clk);
  endtask

  task automatic load_rom(input logic [7:0] prog [16]);
    for (int i = 0; i < 16; i++) rom[i] = prog[i];
  endtask

  // Per-cycle comparison of every observable output against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("rom_addr", int'(rom_addr), m_pc);
      chk("dbg_a",    int'(dbg_a),    m_a);
      chk("dbg_b",    int'(dbg_b),    m_b);
      chk("dbg_c",    int'(dbg_c),    m_c);
      chk("out_port", int'(out_port), m_out);
    end
  end

  logic [7:0] prog [16];

  initial begin
    rst_n = 1'b0; en = 1'b0; in_port = 4'd0;
    for (int i = 0; i < 16; i++) prog[i] = 8'h80;
    load_rom(prog);
    m_pc = 0; m_a = 0; m_b = 0; m_c = 0; m_out = 0;
    @(negedge clk);
    cyc(1'b0, 1'b1, 0);
    chk_on = 1'b1;
    cyc(1'b0, 1'b0, 0);
    chk("reset_pc",  int'(rom_addr), 0);
    chk("reset_out", int'(out_port), 0);

    // 1: standard program with in_port = 3
    for (int i = 0; i < 16; i++) prog[i] = 8'h80;
    prog[0] = 8'h70; prog[1] = 8'h20; prog[2] = 8'h01;
    prog[3] = 8'h40; prog[4] = 8'h90; prog[5] = 8'hF5;
    load_rom(prog);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 3);
    chk("std_out_after5", int'(out_port), 4);
    chk("std_pc_after5",  int'(rom_addr), 5);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 3);
    chk("std_pc_loop",  int'(rom_addr), 5);
    chk("std_out_hold", int'(out_port), 4);

    // 2: carry out of A then JNC not taken / taken
    cyc(1'b0, 1'b1, 0);
    for (int i = 0; i < 16; i++) prog[i] = 8'h80;
    prog[0] = 8'h3F; prog[1] = 8'h01; prog[2] = 8'hE9; prog[3] = 8'hE9;
    load_rom(prog);
    cyc(1'b1, 1'b1, 0); cyc(1'b1, 1'b1, 0);
    chk("addA_wrap_a", int'(dbg_a), 0);
    chk("addA_wrap_c", int'(dbg_c), 1);
    cyc(1'b1, 1'b1, 0);
    chk("jnc_not_taken_pc", int'(rom_addr), 3);
    chk("jnc_clears_c",     int'(dbg_c),    0);
    cyc(1'b1, 1'b1, 0);
    chk("jnc_taken_pc", int'(rom_addr), 9);

    // 3: carry out of B, then MOV A,B clears C
    cyc(1'b0, 1'b1, 0);
    for (int i = 0; i < 16; i++) prog[i] = 8'h80;
    prog[0] = 8'h79; prog[1] = 8'h57; prog[2] = 8'h10;
    load_rom(prog);
    cyc(1'b1, 1'b1, 0); cyc(1'b1, 1'b1, 0);
    chk("addB_wrap_b", int'(dbg_b), 0);
    chk("addB_wrap_c", int'(dbg_c), 1);
    cyc(1'b1, 1'b1, 0);
    chk("movAB_a", int'(dbg_a), 0);
    chk("movAB_c", int'(dbg_c), 0);

    // 4: JMP 15 then NOP at 15 wraps PC to 0
    cyc(1'b0, 1'b1, 0);
    for (int i = 0; i < 16; i++) prog[i] = 8'h80;
    prog[0] = 8'hFF; prog[15] = 8'h80;
    load_rom(prog);
    cyc(1'b1, 1'b1, 0);
    chk("jmp15_pc", int'(rom_addr), 15);
    cyc(1'b1, 1'b1, 0);
    chk("nop_wrap_pc", int'(rom_addr), 0);
    chk("nop_wrap_c",  int'(dbg_c),    0);

    // 5: en low mid-program with in_port changing
    cyc(1'b0, 1'b1, 0);
    for (int i = 0; i < 16; i++) prog[i] = 8'h80;
    prog[0] = 8'h70; prog[1] = 8'h20; prog[2] = 8'h01;
    prog[3] = 8'h40; prog[4] = 8'h90; prog[5] = 8'hF5;
    load_rom(prog);
    cyc(1'b1, 1'b1, 3); cyc(1'b1, 1'b1, 3);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 7 + i);
    chk("stall_pc", int'(rom_addr), 2);
    chk("stall_a",  int'(dbg_a),    3);
    cyc(1'b1, 1'b1, 9);
    chk("resume_a", int'(dbg_a), 4);

    // 6: reset while disabled with A=5, out=4
    cyc(1'b0, 1'b1, 0);
    for (int i = 0; i < 16; i++) prog[i] = 8'h80;
    prog[0] = 8'h35; prog[1] = 8'hB4;
    load_rom(prog);
    cyc(1'b1, 1'b1, 0); cyc(1'b1, 1'b1, 0);
    chk("pre_rst_a",   int'(dbg_a),    5);
    chk("pre_rst_out", int'(out_port), 4);
    cyc(1'b0, 1'b0, 0);
    chk("rst_dis_pc",  int'(rom_addr), 0);
    chk("rst_dis_a",   int'(dbg_a),    0);
    chk("rst_dis_out", int'(out_port), 0);

    // Random programs, enables, inputs and occasional resets
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
      load_rom(prog);
      for (int k = 0; k < 60; k++)
        cyc(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 15)));
    end

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
